// File: rtl/somador_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package somador_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/somador_serial_ctrl_if.sv
// Request/acknowledge bundle between two requesters and the serial adder.
interface somador_serial_ctrl_if
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    req_id_t          gnt_id;
    logic             busy;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  ack0, ack1, sum, cout, gnt_id, busy
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output ack0, ack1, sum, cout, gnt_id, busy
    );
endinterface

// File: rtl/somador_serial_ctrl_full_adder_cell.sv
// One-bit full adder; the only arithmetic cell in the serial adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/somador_serial_ctrl.sv
// Round-robin controller sharing one full-adder cell between two requesters,
// adding the granted operand pair LSB-first, one bit per clock.
module somador_serial_ctrl
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    somador_serial_ctrl_if.slave bus
);
    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    req_id_t          rr_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ack0_r;
    logic             ack1_r;
    req_id_t          gnt_id_r;
    logic             busy_r;

    logic             fa_sum_s;
    logic             fa_co_s;
    logic             grant_valid_s;
    req_id_t          grant_id_s;
    logic [WIDTH-1:0] sum_shift_s;

    full_adder_cell u_fa (
        .a  (a_sr_r[0]),
        .b  (b_sr_r[0]),
        .ci (carry_r),
        .s  (fa_sum_s),
        .co (fa_co_s)
    );

    // Arbitration: a lone request wins; on contention rr picks the one not served last.
    always_comb begin
        grant_valid_s = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            grant_id_s = rr_r;
        end else if (bus.req1) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // New sum bit enters at the MSB so bit i settles in position i after WIDTH shifts.
    always_comb begin
        sum_shift_s            = sum_sr_r >> 1;
        sum_shift_s[WIDTH-1]   = fa_sum_s;
    end

    // Controller FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            rr_r     <= 1'b0;
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            sum_sr_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            gnt_id_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        a_sr_r   <= grant_id_s ? bus.a1 : bus.a0;
                        b_sr_r   <= grant_id_s ? bus.b1 : bus.b0;
                        sum_sr_r <= '0;
                        carry_r  <= 1'b0;
                        cnt_r    <= '0;
                        gnt_id_r <= grant_id_s;
                        busy_r   <= 1'b1;
                        state_r  <= ADD;
                    end
                end
                ADD: begin
                    sum_sr_r <= sum_shift_s;
                    carry_r  <= fa_co_s;
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    sum_r   <= sum_sr_r;
                    cout_r  <= carry_r;
                    ack0_r  <= (gnt_id_r == 1'b0);
                    ack1_r  <= (gnt_id_r == 1'b1);
                    rr_r    <= ~gnt_id_r;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum    = sum_r;
    assign bus.cout   = cout_r;
    assign bus.ack0   = ack0_r;
    assign bus.ack1   = ack1_r;
    assign bus.gnt_id = gnt_id_r;
    assign bus.busy   = busy_r;

endmodule
